// File: rtl/dual_port_mem_if.sv
// rtl/dual_port_mem_if.sv - data-port handshake and fetch-port signal bundle for dual_port_mem
interface dual_port_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic                read;
  logic                write;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W/8-1:0] d_be;
  logic                d_ready;
  logic                d_valid;
  logic                d_err;
  logic                d_perr;
  logic                par_inj;
  logic [ADDR_W-1:0]   i_addr;
  logic [DATA_W-1:0]   i_bus;
  logic                i_perr;

  modport master (
    output read, write, d_addr, d_be, par_inj, i_addr,
    input  d_ready, d_valid, d_err, d_perr, i_bus, i_perr
  );

  modport slave (
    input  read, write, d_addr, d_be, par_inj, i_addr,
    output d_ready, d_valid, d_err, d_perr, i_bus, i_perr
  );
endinterface

// File: rtl/dual_port_mem.sv
// rtl/dual_port_mem.sv - shared word array with registered fetch port and wait-stated data port
// Per-byte even parity storage and checking is built only when MEM_PARITY_EN is defined.
module dual_port_mem #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  dual_port_mem_if.slave   mem_if,
  inout  wire [DATA_W-1:0] d_bus
);
  localparam int         NB        = DATA_W / 8;
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic              pinj_q, pinj_d;
  logic              d_valid_q, d_valid_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] i_bus_q, i_bus_d;
  logic              i_perr_q, i_perr_d;
  logic              d_perr_q, d_perr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              comp;
  logic              wr_sel;
  logic              do_wr;
  logic              do_rd;
  logic              pinj_sel;
  logic              i_hit;
  logic [IDX_W-1:0]  comp_idx;
  logic [IDX_W-1:0]  i_idx;
  logic [NB-1:0]     comp_be;
  logic [DATA_W-1:0] comp_wdata;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;

  logic unused_ok;
  assign unused_ok = ^{mem_if.d_addr, mem_if.i_addr, mem_if.par_inj, pinj_sel};

  // With no wait states the access completes on its accept edge using the live request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    pinj_d     = pinj_q;
    comp       = 1'b0;
    wr_sel     = is_wr_q;
    comp_idx   = idx_q;
    comp_be    = be_q;
    comp_wdata = wdata_q;
    pinj_sel   = pinj_q;
    accept     = (state_q == S_IDLE) && (mem_if.read || mem_if.write);
    d_err_d    = accept && mem_if.read && mem_if.write;

    if (accept) begin
      idx_d   = mem_if.d_addr[IDX_W-1:0];
      be_d    = mem_if.d_be;
      wdata_d = d_bus;
      is_wr_d = mem_if.write;
      pinj_d  = mem_if.par_inj;
      if (WAIT_CYCLES == 0) begin
        comp       = 1'b1;
        wr_sel     = mem_if.write;
        comp_idx   = mem_if.d_addr[IDX_W-1:0];
        comp_be    = mem_if.d_be;
        comp_wdata = d_bus;
        pinj_sel   = mem_if.par_inj;
      end else begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    end else if (state_q == S_WAIT) begin
      if (cnt_q == WAIT_LAST) begin
        comp    = 1'b1;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    do_wr    = comp && wr_sel;
    do_rd    = comp && !wr_sel;
    old_word = mem[comp_idx];
    for (int b = 0; b < NB; b++) begin
      merged[8*b +: 8] = comp_be[b] ? comp_wdata[8*b +: 8] : old_word[8*b +: 8];
    end

    i_idx     = mem_if.i_addr[IDX_W-1:0];
    i_hit     = do_wr && (i_idx == comp_idx);
    i_bus_d   = i_hit ? merged : mem[i_idx];
    rdata_d   = do_rd ? old_word : rdata_q;
    d_valid_d = comp;
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_merged;

  function automatic logic perr_of(input logic [DATA_W-1:0] w, input logic [NB-1:0] p);
    logic e;
    e = 1'b0;
    for (int b = 0; b < NB; b++) begin
      e = e | ((^w[8*b +: 8]) ^ p[b]);
    end
    return e;
  endfunction

  // Only enabled bytes get fresh parity; untouched bytes keep whatever was stored, injected or not.
  always_comb begin
    par_merged = par_mem[comp_idx];
    for (int b = 0; b < NB; b++) begin
      if (comp_be[b]) begin
        par_merged[b] = (^comp_wdata[8*b +: 8]) ^ pinj_sel;
      end
    end
    i_perr_d = i_hit ? perr_of(merged, par_merged) : perr_of(mem[i_idx], par_mem[i_idx]);
    d_perr_d = do_rd ? perr_of(old_word, par_mem[comp_idx]) : d_perr_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_wr) begin
      par_mem[comp_idx] <= par_merged;
    end
  end
`else
  always_comb begin
    i_perr_d = 1'b0;
    d_perr_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      pinj_q    <= 1'b0;
      d_valid_q <= 1'b0;
      d_err_q   <= 1'b0;
      rdata_q   <= '0;
      i_bus_q   <= '0;
      i_perr_q  <= 1'b0;
      d_perr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      pinj_q    <= pinj_d;
      d_valid_q <= d_valid_d;
      d_err_q   <= d_err_d;
      rdata_q   <= rdata_d;
      i_bus_q   <= i_bus_d;
      i_perr_q  <= i_perr_d;
      d_perr_q  <= d_perr_d;
    end
  end

  // Array is never cleared; reset only blocks a write that would complete on the reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && do_wr) begin
      mem[comp_idx] <= merged;
    end
  end

  assign mem_if.d_ready = (state_q == S_IDLE);
  assign mem_if.d_valid = d_valid_q;
  assign mem_if.d_err   = d_err_q;
  assign mem_if.d_perr  = d_perr_q;
  assign mem_if.i_bus   = i_bus_q;
  assign mem_if.i_perr  = i_perr_q;
  assign d_bus          = (mem_if.read && !mem_if.write) ? rdata_q : 'z;
endmodule

// File: tb/tb_dual_port_mem.sv
// tb/tb_dual_port_mem.sv - directed vector bench for dual_port_mem with zero and two wait states
module tb_dual_port_mem;
  localparam logic PAR_EN =
`ifdef MEM_PARITY_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  dual_port_mem_if #(.DATA_W(16), .ADDR_W(16)) if0 ();
  dual_port_mem_if #(.DATA_W(16), .ADDR_W(16)) if2 ();

  wire  [15:0] d_bus0;
  wire  [15:0] d_bus2;
  logic        drv0, drv2;
  logic [15:0] wd0, wd2;
  assign d_bus0 = drv0 ? wd0 : 'z;
  assign d_bus2 = drv2 ? wd2 : 'z;

  dual_port_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_if(if0), .d_bus(d_bus0)
  );
  dual_port_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mem_if(if2), .d_bus(d_bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        pinj;
    logic [15:0] iaddr;
    logic        exp_valid;
    logic        exp_err;
    logic [15:0] exp_rd;
    logic        exp_dperr;
    logic [15:0] exp_i;
    logic        exp_iperr;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [1:0] be, input logic [15:0] wdata, input logic pinj,
                              input logic [15:0] iaddr, input logic ev, input logic ee,
                              input logic [15:0] erd, input logic edp, input logic [15:0] ei,
                              input logic eip);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata; v.pinj = pinj;
    v.iaddr = iaddr; v.exp_valid = ev; v.exp_err = ee; v.exp_rd = erd; v.exp_dperr = edp;
    v.exp_i = ei; v.exp_iperr = eip;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic op2(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [1:0] be, input logic [15:0] wd);
    if2.read = rd; if2.write = wr; if2.d_addr = addr; if2.d_be = be;
    drv2 = wr; wd2 = wd;
  endtask

  task automatic drop2();
    if2.read = 1'b0; if2.write = 1'b0; drv2 = 1'b0;
  endtask

  // Called right after driving a request at a negedge; returns at the negedge showing d_valid.
  task automatic wait2(output int low, output int errs, output int cyc,
                       output logic [15:0] bus, output bit done);
    low = 0; errs = 0; cyc = 0; bus = '0; done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      cyc++;
      if (if2.d_err) errs++;
      if (if2.d_valid) begin
        done = 1'b1;
        bus  = d_bus2;
      end else if (!if2.d_ready) begin
        low++;
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          low, errs, cyc, vpulse;
    logic [15:0] bus;
    bit          done;

    n_chk = 0; n_err = 0;
    rst_n = 1'b0;
    drv0 = 1'b0; wd0 = '0; drv2 = 1'b0; wd2 = '0;
    if0.read = 0; if0.write = 0; if0.d_addr = '0; if0.d_be = '0; if0.par_inj = 0; if0.i_addr = '0;
    if2.read = 0; if2.write = 0; if2.d_addr = '0; if2.d_be = '0; if2.par_inj = 0; if2.i_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", if0.d_ready, 1);
    check("rst_valid0", if0.d_valid, 0);
    check("rst_err0", if0.d_err, 0);
    check("rst_ibus0", if0.i_bus, 0);
    check("rst_iperr0", if0.i_perr, 0);
    check("rst_dperr0", if0.d_perr, 0);
    check("rst_ready2", if2.d_ready, 1);
    rst_n = 1'b1;

    tbl[0]  = mk(0, 1, 16'h0000, 2'b11, 16'hdead, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'hdead, 0);
    tbl[1]  = mk(0, 1, 16'h0001, 2'b11, 16'hbeef, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'hdead, 0);
    tbl[2]  = mk(0, 1, 16'h0001, 2'b10, 16'h12ff, 0, 16'h0001, 1, 0, 16'h0000, 0, 16'h12ef, 0);
    tbl[3]  = mk(1, 0, 16'h0001, 2'b00, 16'h0000, 0, 16'h0001, 1, 0, 16'h12ef, 0, 16'h12ef, 0);
    tbl[4]  = mk(0, 1, 16'h0405, 2'b11, 16'hcafe, 0, 16'h0005, 1, 0, 16'h0000, 0, 16'hcafe, 0);
    tbl[5]  = mk(1, 0, 16'h0005, 2'b00, 16'h0000, 0, 16'h0405, 1, 0, 16'hcafe, 0, 16'hcafe, 0);
    tbl[6]  = mk(1, 1, 16'h0002, 2'b11, 16'h1234, 0, 16'h0002, 1, 1, 16'h0000, 0, 16'h1234, 0);
    tbl[7]  = mk(1, 0, 16'h0002, 2'b00, 16'h0000, 0, 16'h0002, 1, 0, 16'h1234, 0, 16'h1234, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'hdead, 0);
    tbl[9]  = mk(0, 1, 16'h0000, 2'b01, 16'h0077, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'hde77, 0);
    tbl[10] = mk(1, 0, 16'h0400, 2'b00, 16'h0000, 0, 16'h0001, 1, 0, 16'hde77, 0, 16'h12ef, 0);
    tbl[11] = mk(0, 1, 16'h0007, 2'b11, 16'h0f0f, 1, 16'h0007, 1, 0, 16'h0000, 0, 16'h0f0f, PAR_EN);
    tbl[12] = mk(1, 0, 16'h0007, 2'b00, 16'h0000, 0, 16'h0007, 1, 0, 16'h0f0f, PAR_EN, 16'h0f0f, PAR_EN);
    tbl[13] = mk(0, 1, 16'h0007, 2'b01, 16'h0000, 0, 16'h0007, 1, 0, 16'h0000, 0, 16'h0f00, PAR_EN);
    tbl[14] = mk(0, 1, 16'h0007, 2'b10, 16'h1100, 0, 16'h0007, 1, 0, 16'h0000, 0, 16'h1100, 0);
    tbl[15] = mk(1, 0, 16'h0007, 2'b00, 16'h0000, 0, 16'h0007, 1, 0, 16'h1100, 0, 16'h1100, 0);

    for (int k = 0; k < 16; k++) begin
      if0.read = tbl[k].rd; if0.write = tbl[k].wr; if0.d_addr = tbl[k].addr;
      if0.d_be = tbl[k].be; if0.par_inj = tbl[k].pinj; if0.i_addr = tbl[k].iaddr;
      drv0 = tbl[k].wr; wd0 = tbl[k].wdata;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_ready", k), if0.d_ready, 1);
      check($sformatf("v%0d_valid", k), if0.d_valid, tbl[k].exp_valid);
      check($sformatf("v%0d_err", k), if0.d_err, tbl[k].exp_err);
      check($sformatf("v%0d_ibus", k), if0.i_bus, tbl[k].exp_i);
      check($sformatf("v%0d_iperr", k), if0.i_perr, tbl[k].exp_iperr);
      if (tbl[k].rd && !tbl[k].wr) begin
        check($sformatf("v%0d_rdata", k), d_bus0, tbl[k].exp_rd);
        check($sformatf("v%0d_dperr", k), if0.d_perr, tbl[k].exp_dperr);
      end
    end

    // Once read falls the memory must release d_bus so another driver owns it cleanly.
    if0.read = 1'b0; if0.write = 1'b0; drv0 = 1'b1; wd0 = 16'h5a5a;
    #1;
    check("bus_release0", d_bus0, 16'h5a5a);
    drv0 = 1'b0;

    @(negedge clk);
    op2(0, 1, 16'h0001, 2'b11, 16'hbeef);
    wait2(low, errs, cyc, bus, done);
    check("w2a_done", done, 1);
    check("w2a_low", low, 2);
    op2(0, 1, 16'h0001, 2'b10, 16'h12ff);
    wait2(low, errs, cyc, bus, done);
    check("w2b_low", low, 2);
    op2(1, 0, 16'h0001, 2'b00, 16'h0000);
    wait2(low, errs, cyc, bus, done);
    check("r2a_done", done, 1);
    check("r2a_low", low, 2);
    check("r2a_data", bus, 16'h12ef);
    wait2(low, errs, cyc, bus, done);
    check("r2b_done", done, 1);
    check("r2b_cycles", cyc, 3);
    check("r2b_data", bus, 16'h12ef);
    drop2();

    op2(1, 1, 16'h0003, 2'b11, 16'h4242);
    wait2(low, errs, cyc, bus, done);
    check("ill2_done", done, 1);
    check("ill2_errs", errs, 1);
    drop2();
    op2(1, 0, 16'h0003, 2'b00, 16'h0000);
    wait2(low, errs, cyc, bus, done);
    check("ill2_rdata", bus, 16'h4242);
    check("ill2_rd_errs", errs, 0);
    drop2();

    op2(0, 1, 16'h0001, 2'b11, 16'h7777);
    @(negedge clk);
    check("rstw_ready_low", if2.d_ready, 0);
    rst_n = 1'b0;
    drop2();
    if2.i_addr = 16'h0001;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw_ready", if2.d_ready, 1);
    check("rstw_valid", if2.d_valid, 0);
    check("rstw_err", if2.d_err, 0);
    check("rstw_ibus", if2.i_bus, 0);
    vpulse = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (if2.d_valid) vpulse++;
    end
    check("rstw_no_valid", vpulse, 0);
    check("rstw_ibus_old", if2.i_bus, 16'h12ef);
    op2(1, 0, 16'h0001, 2'b00, 16'h0000);
    wait2(low, errs, cyc, bus, done);
    check("rstw_rdata", bus, 16'h12ef);
    drop2();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
